// File: rtl/pipe_fifo_pkg.sv
// Shared datapath constants for the pipe FIFO: default geometry and the occupancy-counter width helper.
// Included by the interface, the pointer sub-module and the top so every width is derived from one place.
package pipe_fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_fifo_if.sv
// Producer/consumer bundle for pipe_fifo: push/pop requests, flush, head data and status flags.
// The slave modport is the FIFO itself; the master modport is the pipeline stage driving it.
interface pipe_fifo_if
  import pipe_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = cnt_w(DEPTH);

  logic             clear;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push, push_data, pop,
    input  pop_data, full, empty, count, overflow, underflow
  );

  modport slave (
    input  clear, push, push_data, pop,
    output pop_data, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH ring pointer: advances by one on inc, returns to 0 on clear or reset; one-cycle update.
// No backpressure of its own; the caller gates inc with the accept condition.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // DEPTH is a power of two, so natural overflow of the PW-bit add is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_fifo.sv
// First-word fall-through FIFO with sticky overflow/underflow and synchronous flush; pop_data has zero latency, a push is visible next cycle.
// Push while full is dropped unless a pop is accepted the same cycle; PIPE_FIFO_BYPASS_EN enables push+pop pass-through while empty.
module pipe_fifo
  import pipe_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  pipe_fifo_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             underflow_q;
  logic             underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] we;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             push_acc;
  logic             pop_acc;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
`ifdef PIPE_FIFO_BYPASS_EN
    bypass = bus.push && bus.pop && empty;
`else
    bypass = 1'b0;
`endif
    // A flush squashes both requests, so nothing moves while clear is high.
    pop_acc  = bus.pop && !empty && !bus.clear;
    push_acc = bus.push && !bypass && !bus.clear && (!full || pop_acc);
  end

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!bus.clear) begin
      if (bus.push && full && !bus.pop) begin
        overflow_d = 1'b1;
      end
      if (bus.pop && empty && !bypass) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.clear) begin
      count_d = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      we[i]    = push_acc && (wr_ptr == PW'(i));
      mem_d[i] = we[i] ? bus.push_data : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; only occupancy decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  assign bus.pop_data  = bypass ? bus.push_data : mem_q[rd_ptr];
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  a_not_full_and_empty : assert property (@(posedge clk) disable iff (reset) !(full && empty));
  a_count_in_range     : assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));

endmodule
